// File: rtl/parallel_in_serial_out_ble.sv
// Word-to-bit serializer for the BLE TX path: valid/ready word input, one bit per en strobe.
// A one-word holding register lets the next word queue up so back-to-back words go out with no gap.
module parallel_in_serial_out_ble #(
    parameter int DATA      = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic [DATA-1:0] data_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic            en,
    output logic            data_out,
    output logic            valid_out,
    output logic            last,
    output logic            busy
);
    localparam int CW = $clog2(DATA);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [DATA-1:0] hold_reg, hold_next;
    logic [DATA-1:0] sh_reg, sh_next;
    logic            hold_full_reg, hold_full_next;
    logic            data_out_reg, data_out_next;
    logic            valid_out_reg, valid_out_next;
    logic            last_reg, last_next;

    function automatic logic [CW-1:0] idx(input logic [CW-1:0] c);
        return MSB_FIRST ? (LAST_CNT - c) : c;
    endfunction

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        hold_next      = hold_reg;
        sh_next        = sh_reg;
        hold_full_next = hold_full_reg;
        data_out_next  = data_out_reg;
        valid_out_next = 1'b0;
        last_next      = 1'b0;

        if (clear) begin
            hold_full_next = 1'b0;
            state_next     = IDLE;
            cnt_next       = '0;
        end else begin
            // Accept needs an empty hold, consume needs a full one, so they never collide.
            if (valid_in && !hold_full_reg) begin
                hold_next      = data_in;
                hold_full_next = 1'b1;
            end
            if (en) begin
                case (state_reg)
                    IDLE: begin
                        if (hold_full_reg) begin
                            sh_next        = hold_reg;
                            hold_full_next = 1'b0;
                            data_out_next  = hold_reg[idx('0)];
                            valid_out_next = 1'b1;
                            cnt_next       = CW'(1);
                            state_next     = SHIFT;
                        end
                    end
                    SHIFT: begin
                        data_out_next  = sh_reg[idx(cnt_reg)];
                        valid_out_next = 1'b1;
                        last_next      = (cnt_reg == LAST_CNT);
                        if (cnt_reg == LAST_CNT) begin
                            cnt_next   = '0;
                            state_next = IDLE;
                        end else begin
                            cnt_next = cnt_reg + CW'(1);
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            hold_reg      <= '0;
            sh_reg        <= '0;
            hold_full_reg <= 1'b0;
            data_out_reg  <= 1'b0;
            valid_out_reg <= 1'b0;
            last_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            hold_reg      <= hold_next;
            sh_reg        <= sh_next;
            hold_full_reg <= hold_full_next;
            data_out_reg  <= data_out_next;
            valid_out_reg <= valid_out_next;
            last_reg      <= last_next;
        end
    end

    assign ready_out = ~hold_full_reg;
    assign data_out  = data_out_reg;
    assign valid_out = valid_out_reg;
    assign last      = last_reg;
    assign busy      = (state_reg == SHIFT) | hold_full_reg;

endmodule

// File: tb/tb_parallel_in_serial_out_ble.sv
// Directed bench for parallel_in_serial_out_ble: LSB-first and MSB-first instances share stimulus.
module tb_parallel_in_serial_out_ble;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        en = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;

    logic ready_lsb, dout_lsb, vo_lsb, last_lsb, busy_lsb;
    logic ready_msb, dout_msb, vo_msb, last_msb, busy_msb;

    int checks = 0;
    int errors = 0;

    logic [31:0] words_q[$];
    logic [31:0] got_q[$];
    int          acc_q[$];
    int pulses, last_pulses, bad_last, bad_strobe, bad_hold, first_cyc, last_cyc;
    logic first_bit;

    always #5 clk = ~clk;

    parallel_in_serial_out_ble #(.DATA(32), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .clear(clear), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_lsb), .en(en), .data_out(dout_lsb), .valid_out(vo_lsb),
        .last(last_lsb), .busy(busy_lsb)
    );

    parallel_in_serial_out_ble #(.DATA(32), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .clear(clear), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_msb), .en(en), .data_out(dout_msb), .valid_out(vo_msb),
        .last(last_msb), .busy(busy_msb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Drives queued words through the handshake and monitors one instance's serial output.
    task automatic run(input int cycles, input int period, input bit sel, input int stop_at);
        logic rdy, dv, db, dl, prev;
        logic [31:0] asm_w;
        pulses = 0; last_pulses = 0; bad_last = 0; bad_strobe = 0; bad_hold = 0;
        first_cyc = -1; last_cyc = -1; first_bit = 1'b0;
        got_q.delete(); acc_q.delete();
        asm_w = '0;
        prev = sel ? dout_msb : dout_lsb;
        for (int c = 0; c < cycles; c++) begin
            en = ((c % period) == 0);
            valid_in = (words_q.size() > 0);
            data_in = valid_in ? words_q[0] : 32'h0;
            rdy = ready_lsb;
            @(posedge clk); #1;
            if (valid_in && rdy) begin
                void'(words_q.pop_front());
                acc_q.push_back(c);
            end
            dv = sel ? vo_msb : vo_lsb;
            db = sel ? dout_msb : dout_lsb;
            dl = sel ? last_msb : last_lsb;
            if (dv && !en) bad_strobe++;
            if (!dv && db !== prev) bad_hold++;
            if (dl && !dv) bad_last++;
            prev = db;
            if (dv) begin
                if (pulses == 0) begin
                    first_cyc = c;
                    first_bit = db;
                end
                last_cyc = c;
                pulses++;
                asm_w = sel ? {asm_w[30:0], db} : {db, asm_w[31:1]};
                if (pulses % 32 == 0) got_q.push_back(asm_w);
                if (dl) begin
                    last_pulses++;
                    if (pulses % 32 != 0) bad_last++;
                end else if (pulses % 32 == 0) begin
                    bad_last++;
                end
            end
            if (stop_at != 0 && pulses == stop_at) break;
        end
        en = 1'b0;
        valid_in = 1'b0;
        words_q.delete();
    endtask

    function automatic logic [31:0] got(input int i);
        return (got_q.size() > i) ? got_q[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready_lsb), 1);
        check("rst_busy", 32'(busy_lsb), 0);
        check("rst_valid", 32'(vo_lsb), 0);
        check("rst_last", 32'(last_lsb), 0);
        check("rst_dout", 32'(dout_lsb), 0);
        reset = 1'b0;

        // Single word, continuous en, LSB first
        words_q = '{32'hA5A5_0F01};
        run(40, 1, 1'b0, 0);
        check("t2_pulses", pulses, 32);
        check("t2_word", got(0), 32'hA5A5_0F01);
        check("t2_first_bit", 32'(first_bit), 1);
        check("t2_last_cnt", last_pulses, 1);
        check("t2_bad_last", bad_last, 0);
        check("t2_latency", (acc_q.size() > 0) ? (first_cyc - acc_q[0]) : -1, 1);
        check("t2_idle_busy", 32'(busy_lsb), 0);

        // Two words back-to-back
        words_q = '{32'h0000_FFFF, 32'h1234_5678};
        run(70, 1, 1'b0, 0);
        check("t3_pulses", pulses, 64);
        check("t3_nogap", last_cyc - first_cyc + 1, 64);
        check("t3_word0", got(0), 32'h0000_FFFF);
        check("t3_word1", got(1), 32'h1234_5678);
        check("t3_last_cnt", last_pulses, 2);
        check("t3_bad_last", bad_last, 0);
        check("t3_acc_during_shift", (acc_q.size() > 1 && acc_q[1] < first_cyc + 31) ? 1 : 0, 1);

        // en every 4th cycle
        words_q = '{32'h5A5A_C33C};
        run(140, 4, 1'b0, 0);
        check("t4_pulses", pulses, 32);
        check("t4_word", got(0), 32'h5A5A_C33C);
        check("t4_span", last_cyc - first_cyc + 4, 128);
        check("t4_bad_strobe", bad_strobe, 0);
        check("t4_bad_hold", bad_hold, 0);

        // MSB first
        words_q = '{32'h8000_0001};
        run(40, 1, 1'b1, 0);
        check("t5_pulses", pulses, 32);
        check("t5_first_bit", 32'(first_bit), 1);
        check("t5_word", got(0), 32'h8000_0001);
        check("t5_last_cnt", last_pulses, 1);
        check("t5_bad_last", bad_last, 0);

        // Async reset mid-word
        words_q = '{32'hFFFF_FFFF};
        run(40, 1, 1'b0, 10);
        check("t1_reached_bit10", pulses, 10);
        reset = 1'b1;
        #1;
        check("t1_async_valid", 32'(vo_lsb), 0);
        check("t1_async_ready", 32'(ready_lsb), 1);
        check("t1_async_busy", 32'(busy_lsb), 0);
        check("t1_async_dout", 32'(dout_lsb), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        words_q = '{32'hC3C3_0002};
        run(40, 1, 1'b0, 0);
        check("t1_next_pulses", pulses, 32);
        check("t1_next_first_bit", 32'(first_bit), 0);
        check("t1_next_word", got(0), 32'hC3C3_0002);

        // Clear with a second word waiting in hold
        words_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        run(40, 1, 1'b0, 10);
        check("t6_hold_full", 32'(ready_lsb), 0);
        clear = 1'b1; en = 1'b1; valid_in = 1'b1; data_in = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        check("t6_valid", 32'(vo_lsb), 0);
        check("t6_ready", 32'(ready_lsb), 1);
        check("t6_busy", 32'(busy_lsb), 0);
        check("t6_dout_held", 32'(dout_lsb), 1);
        clear = 1'b0; en = 1'b0; valid_in = 1'b0;
        run(40, 1, 1'b0, 0);
        check("t6_no_bits", pulses, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
